// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl
//   Nonce-search controller. It drives the nonce into the concatenador and
//   pulses a launch strobe. It then waits for micro_hash to report hash_done,
//   and checks the two low hash bytes against the target byte. On a miss it
//   moves to the next nonce. The search stops on a hit, when the nonce range
//   is used up, or when a hash never completes.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   start_i        1-cycle pulse: begin a search at nonce_base_i (ignored while busy)
//   nonce_base_i   first nonce of the search
//   target_i       difficulty target byte, sampled in CHECK only
//   hash_done_i    micro_hash result valid (may be held high)
//   h_in_i         micro_hash H_out
//   nonce_o        nonce currently applied to the concatenador
//   hash_start_o   1-cycle launch pulse for the current nonce
//   busy_o         high while launching, waiting or checking
//   found_o        sticky: valid nonce found
//   exhausted_o    sticky: range ended without a hit
//   timeout_err_o  sticky: hash_done missing for TIMEOUT cycles
//   nonce_found_o  winning nonce, valid while found_o=1
//   hash_found_o   winning hash, valid while found_o=1
module nonce_search_ctrl #(
  parameter logic [31:0] NONCE_MAX = 32'hFFFF_FFFF,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [3:0][7:0] nonce_base_i,
  input  logic [7:0]      target_i,
  input  logic            hash_done_i,
  input  logic [2:0][7:0] h_in_i,
  output logic [3:0][7:0] nonce_o,
  output logic            hash_start_o,
  output logic            busy_o,
  output logic            found_o,
  output logic            exhausted_o,
  output logic            timeout_err_o,
  output logic [3:0][7:0] nonce_found_o,
  output logic [2:0][7:0] hash_found_o
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, TIMEOUT_ST
  } state_t;

  localparam logic [15:0] WAIT_LAST = TIMEOUT - 16'd1;

  state_t          state_q;
  logic [3:0][7:0] nonce_q;
  logic [2:0][7:0] hash_q;
  logic [3:0][7:0] nonce_found_q;
  logic [2:0][7:0] hash_found_q;
  logic [15:0]     wait_cnt_q;
  logic            done_prev_q;
  logic            hash_start_q;
  logic            busy_q;
  logic            found_q;
  logic            exhausted_q;
  logic            timeout_err_q;

  logic done_rise;
  logic hash_ok;

  // done_prev_q follows hash_done_i every cycle. A level that is still high
  // from the previous nonce therefore never shows up as a rising edge.
  assign done_rise = hash_done_i && !done_prev_q;
  assign hash_ok   = (hash_q[0] < target_i) && (hash_q[1] < target_i);

  // Every output is a register. hash_start_q and busy_q are set on the
  // transition into the state where they must be high, so each one lines up
  // exactly with its state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      nonce_q       <= '0;
      hash_q        <= '0;
      nonce_found_q <= '0;
      hash_found_q  <= '0;
      wait_cnt_q    <= '0;
      done_prev_q   <= 1'b0;
      hash_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      done_prev_q  <= hash_done_i;
      hash_start_q <= 1'b0;
      case (state_q)
        IDLE, FOUND, EXHAUSTED, TIMEOUT_ST: begin
          if (start_i) begin
            nonce_q       <= nonce_base_i;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            hash_start_q  <= 1'b1;
            state_q       <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            hash_q  <= h_in_i;
            state_q <= CHECK;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= TIMEOUT_ST;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        CHECK: begin
          if (hash_ok) begin
            nonce_found_q <= nonce_q;
            hash_found_q  <= hash_q;
            found_q       <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= FOUND;
          end else if (nonce_q == NONCE_MAX) begin
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= EXHAUSTED;
          end else begin
            nonce_q      <= nonce_q + 32'd1;
            hash_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nonce_o       = nonce_q;
  assign hash_start_o  = hash_start_q;
  assign busy_o        = busy_q;
  assign found_o       = found_q;
  assign exhausted_o   = exhausted_q;
  assign timeout_err_o = timeout_err_q;
  assign nonce_found_o = nonce_found_q;
  assign hash_found_o  = hash_found_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
module tb_nonce_search_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [3:0][7:0] nonce_base;
  logic [7:0]      target;
  logic            hash_done;
  logic [2:0][7:0] h_in;
  logic [3:0][7:0] nonce;
  logic            hash_start, busy, found, exhausted, timeout_err;
  logic [3:0][7:0] nonce_found;
  logic [2:0][7:0] hash_found;

  nonce_search_ctrl #(.NONCE_MAX(32'h3), .TIMEOUT(16'd16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .nonce_base_i(nonce_base),
    .target_i(target), .hash_done_i(hash_done), .h_in_i(h_in),
    .nonce_o(nonce), .hash_start_o(hash_start), .busy_o(busy),
    .found_o(found), .exhausted_o(exhausted), .timeout_err_o(timeout_err),
    .nonce_found_o(nonce_found), .hash_found_o(hash_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          f, e, t;
    logic [31:0] n, nf;
    logic [23:0] hf;
    int          launches;
    int          delta;   // cycles from last launch to terminal; 0 = unchecked
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  int done_cnt = 0;
  int mode = 0;           // 0: never answer, 1: pulse, 2: held high
  logic [23:0] tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // micro_hash model: answers each launch with tbl[nonce[1:0]]
  initial begin : hash_model
    logic [1:0] n;
    hash_done = 1'b0;
    h_in = '0;
    forever begin
      @(negedge clk);
      if (!reset && hash_start && mode != 0) begin
        n = nonce[1:0];
        if (mode == 2) begin
          repeat (3) @(posedge clk);
          #1 hash_done = 1'b0;
          @(posedge clk);
          #1;
        end else begin
          repeat (2) @(posedge clk);
          #1;
        end
        h_in = tbl[n];
        hash_done = 1'b1;
        if (mode == 1) begin
          @(posedge clk);
          #1 hash_done = 1'b0;
        end
      end
    end
  end

  // Monitor: a busy falling edge marks a terminal result; pop and compare.
  initial begin : monitor
    bit busy_prev = 1'b0;
    int launches = 0, cyc = 0, last_hs = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev = 1'b0;
        launches = 0;
      end else begin
        cyc++;
        if (hash_start) begin
          launches++;
          last_hs = cyc;
        end
        if (busy_prev && !busy) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 64'(busy_prev), 64'd0);
          end else begin
            e = q.pop_front();
            chk("found", 64'(found), 64'(e.f));
            chk("exhausted", 64'(exhausted), 64'(e.e));
            chk("timeout_err", 64'(timeout_err), 64'(e.t));
            chk("nonce", 64'(nonce), 64'(e.n));
            chk("launches", 64'(launches), 64'(e.launches));
            if (e.f) begin
              chk("nonce_found", 64'(nonce_found), 64'(e.nf));
              chk("hash_found", 64'(hash_found), 64'(e.hf));
            end
            if (e.delta != 0) chk("timeout_latency", 64'(cyc - last_hs), 64'(e.delta));
          end
          launches = 0;
          done_cnt++;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] b);
    @(posedge clk);
    #1 start = 1'b1;
    nonce_base = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int want);
    int k = 0;
    while (done_cnt < want && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < want) chk("result_wait_expired", 64'(done_cnt), 64'(want));
  endtask

  task automatic run(input logic [31:0] b, input logic [7:0] tg, input bit f, e, t,
                     input logic [31:0] n, input logic [23:0] hf, input int l, input int d);
    exp_t x;
    x.f = f; x.e = e; x.t = t; x.n = n; x.nf = n; x.hf = hf;
    x.launches = l; x.delta = d;
    q.push_back(x);
    target = tg;
    pulse_start(b);
    wait_done(done_cnt + 1);
  endtask

  initial begin : stim
    int hs;
    exp_t x;
    reset = 1'b1; start = 1'b0; nonce_base = '0; target = '0;
    #1;
    chk("por_outputs", {nonce, 7'(0), hash_start, busy, found, exhausted, timeout_err},
        64'd0);
    chk("por_found_regs", {nonce_found, hash_found}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset mid-WAIT
    mode = 0;
    pulse_start(32'h2);
    repeat (4) @(posedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs", {nonce, 7'(0), hash_start, busy, found, exhausted, timeout_err},
        64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hs = 0;
    repeat (20) begin
      @(negedge clk);
      if (hash_start) hs++;
    end
    chk("no_launch_after_reset", 64'(hs), 64'd0);

    // 2: hit on third hash
    mode = 1;
    tbl[0] = 24'h55200F; tbl[1] = 24'h55200F; tbl[2] = 24'h55050F; tbl[3] = 24'h55200F;
    run(32'h0, 8'h10, 1, 0, 0, 32'h2, 24'h55050F, 3, 0);

    // 3: strict compare on each checked byte
    tbl[0] = 24'h001005; tbl[1] = 24'h000F05;
    run(32'h0, 8'h10, 1, 0, 0, 32'h1, 24'h000F05, 2, 0);
    tbl[0] = 24'h000510; tbl[1] = 24'h00050F;
    run(32'h0, 8'h10, 1, 0, 0, 32'h1, 24'h00050F, 2, 0);

    // 4: range exhausted, no wrap; base at the limit tries one hash
    tbl[0] = 24'hFFFFFF; tbl[1] = 24'hFFFFFF; tbl[2] = 24'hFFFFFF; tbl[3] = 24'hFFFFFF;
    run(32'h0, 8'h10, 0, 1, 0, 32'h3, 24'h0, 4, 0);
    run(32'h3, 8'h10, 0, 1, 0, 32'h3, 24'h0, 1, 0);

    // 5: hash_done never rises
    mode = 0;
    run(32'h1, 8'h10, 0, 0, 1, 32'h1, 24'h0, 1, 17);

    // 6: hash_done held high across nonces; start while busy ignored
    mode = 2;
    tbl[0] = 24'h00FF00; tbl[1] = 24'h000101; tbl[2] = 24'hFFFFFF; tbl[3] = 24'hFFFFFF;
    x.f = 1; x.e = 0; x.t = 0; x.n = 32'h1; x.nf = 32'h1; x.hf = 24'h000101;
    x.launches = 2; x.delta = 0;
    q.push_back(x);
    target = 8'h10;
    pulse_start(32'h0);
    repeat (3) @(posedge clk);
    chk("busy_during_search", 64'(busy), 64'd1);
    pulse_start(32'h2);
    wait_done(done_cnt + 1);
    mode = 0;
    #1 hash_done = 1'b0;

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
